// File: rtl/ws2812b_frame_tx.sv
// WS2812B frame transmitter: streams NUM_PIXELS pixels MSB-first as pulse-width
// coded bits through a one-entry prefetch buffer, then holds the line low to latch.
module ws2812b_frame_tx #(
    parameter  int T0H_CYCLES     = 5,
    parameter  int T1H_CYCLES     = 10,
    parameter  int BIT_CYCLES     = 15,
    parameter  int BITS_PER_PIXEL = 24,
    parameter  int NUM_PIXELS     = 64,
    parameter  int LATCH_CYCLES   = 3600,
    localparam int IDX_W          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic [IDX_W-1:0]          pixel_index,
    output logic                      ws2812b_out,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun
);
    localparam int BC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BI_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int LC_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(BIT_CYCLES - 1);
    localparam logic [BC_W-1:0]  T0H      = BC_W'(T0H_CYCLES);
    localparam logic [BC_W-1:0]  T1H      = BC_W'(T1H_CYCLES);
    localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(BITS_PER_PIXEL - 1);
    localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(LATCH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PIXELS - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          NUM_PIXELS >= 1 && BITS_PER_PIXEL >= 1 && LATCH_CYCLES >= 1)) begin : g_param_check
        $error("ws2812b_frame_tx: illegal timing or size parameters");
    end

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, LATCH} state_t;

    state_t                    state_q, state_d;
    logic [BC_W-1:0]           bit_cnt_q;
    logic [BI_W-1:0]           bit_idx_q;
    logic [LC_W-1:0]           latch_cnt_q;
    logic [IDX_W-1:0]          pix_cnt_q;
    logic [IDX_W-1:0]          pixel_index_q;
    logic                      all_taken_q;
    logic                      buf_full_q;
    logic                      frame_done_q;
    logic [BITS_PER_PIXEL-1:0] buf_q;
    logic [BITS_PER_PIXEL-1:0] shreg_q;

    logic bit_end, pix_end, last_pix, latch_end, take;

    assign bit_end   = (bit_cnt_q == BIT_LAST);
    assign pix_end   = bit_end && (bit_idx_q == BI_LAST);
    assign last_pix  = (pix_cnt_q == IDX_LAST);
    assign latch_end = (latch_cnt_q == LC_LAST);
    assign take      = pixel_valid && pixel_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A pixel arriving in the boundary cycle with the buffer empty is loaded
    // straight into the shifter, so it still counts as on time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (start) state_d = WAIT_FIRST;
            WAIT_FIRST: if (take)  state_d = SEND;
            SEND:       if (pix_end && (last_pix || (!buf_full_q && !take))) state_d = LATCH;
            LATCH:      if (latch_end) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        pixel_ready = 1'b0;
        ws2812b_out = 1'b0;
        underrun    = 1'b0;
        case (state_q)
            WAIT_FIRST: pixel_ready = 1'b1;
            SEND: begin
                pixel_ready = !all_taken_q && (!buf_full_q || pix_end);
                ws2812b_out = shreg_q[BITS_PER_PIXEL-1] ? (bit_cnt_q < T1H) : (bit_cnt_q < T0H);
                underrun    = pix_end && !last_pix && !buf_full_q && !pixel_valid;
            end
            default: ;
        endcase
    end

    assign frame_done  = frame_done_q;
    assign pixel_index = pixel_index_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            latch_cnt_q   <= '0;
            pix_cnt_q     <= '0;
            pixel_index_q <= '0;
            all_taken_q   <= 1'b0;
            buf_full_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= (state_q == LATCH) && latch_end;
            if (take) begin
                if (pixel_index_q == IDX_LAST) all_taken_q <= 1'b1;
                else                           pixel_index_q <= pixel_index_q + IDX_W'(1);
            end
            case (state_q)
                IDLE: begin
                    bit_cnt_q  <= '0;
                    bit_idx_q  <= '0;
                    buf_full_q <= 1'b0;
                end
                SEND: begin
                    bit_cnt_q <= bit_end ? '0 : bit_cnt_q + BC_W'(1);
                    if (bit_end) bit_idx_q <= pix_end ? '0 : bit_idx_q + BI_W'(1);
                    if (pix_end && !last_pix) pix_cnt_q <= pix_cnt_q + IDX_W'(1);
                    buf_full_q <= pix_end ? (buf_full_q && take) : (buf_full_q || take);
                end
                LATCH: begin
                    latch_cnt_q <= latch_end ? '0 : latch_cnt_q + LC_W'(1);
                    if (latch_end) begin
                        pix_cnt_q     <= '0;
                        pixel_index_q <= '0;
                        all_taken_q   <= 1'b0;
                        buf_full_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel data path carries no reset; only the control above is reset.
    always_ff @(posedge clk) begin
        if (take) buf_q <= pixel_data;
        if (take && (state_q == WAIT_FIRST || (state_q == SEND && pix_end && !buf_full_q)))
            shreg_q <= pixel_data;
        else if (state_q == SEND && pix_end)
            shreg_q <= buf_q;
        else if (state_q == SEND && bit_end)
            shreg_q <= {shreg_q[BITS_PER_PIXEL-2:0], 1'b0};
    end

endmodule

// File: tb/tb_ws2812b_frame_tx.sv
// Scoreboard bench for ws2812b_frame_tx: three configurations, one active at a time,
// expected bit levels queued at each pixel handshake and checked on the serial line.
module tb_ws2812b_frame_tx;
    localparam int BITC  = 15;
    localparam int LATCH = 3600;

    logic        clk = 1'b0;
    logic        rst_n, start, pixel_valid;
    logic [31:0] pixel_data;
    logic [31:0] pix [4];
    int          sel;

    always #5 clk = ~clk;

    logic       a_ready, a_out, a_busy, a_done, a_under;
    logic [0:0] a_index;
    logic       b_ready, b_out, b_busy, b_done, b_under;
    logic [1:0] b_index;
    logic       c_ready, c_out, c_busy, c_done, c_under;
    logic [0:0] c_index;

    ws2812b_frame_tx #(.NUM_PIXELS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0),
        .pixel_data(pixel_data[23:0]), .pixel_valid(pixel_valid && sel == 0),
        .pixel_ready(a_ready), .pixel_index(a_index), .ws2812b_out(a_out),
        .busy(a_busy), .frame_done(a_done), .underrun(a_under));

    ws2812b_frame_tx #(.NUM_PIXELS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1),
        .pixel_data(pixel_data[23:0]), .pixel_valid(pixel_valid && sel == 1),
        .pixel_ready(b_ready), .pixel_index(b_index), .ws2812b_out(b_out),
        .busy(b_busy), .frame_done(b_done), .underrun(b_under));

    ws2812b_frame_tx #(.BITS_PER_PIXEL(32), .NUM_PIXELS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid && sel == 2),
        .pixel_ready(c_ready), .pixel_index(c_index), .ws2812b_out(c_out),
        .busy(c_busy), .frame_done(c_done), .underrun(c_under));

    logic m_ready, m_out, m_busy, m_done, m_under;
    int   m_index;

    always_comb begin
        m_ready = a_ready; m_out = a_out; m_busy = a_busy;
        m_done  = a_done;  m_under = a_under; m_index = int'(a_index);
        if (sel == 1) begin
            m_ready = b_ready; m_out = b_out; m_busy = b_busy;
            m_done  = b_done;  m_under = b_under; m_index = int'(b_index);
        end else if (sel == 2) begin
            m_ready = c_ready; m_out = c_out; m_busy = c_busy;
            m_done  = c_done;  m_under = c_under; m_index = int'(c_index);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int bpp_of(input int s);
        return (s == 2) ? 32 : 24;
    endfunction

    // Monitor / scoreboard
    bit exp_q[$];
    bit cur, seen_low, bad, mon_hs;
    int active = 0, cyc = 0, scyc = 0, hi = 0;
    int in_latch = 0, latch_n = 0, latch_hi = 0, exp_idx = 0;
    int f_bits = 0, f_under = 0, f_under_cyc = 0, f_send = 0, done_seen = 0, d0 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            active = 0; cyc = 0; scyc = 0; in_latch = 0; exp_idx = 0;
        end else begin
            mon_hs = m_ready && pixel_valid;
            if (m_under) begin
                f_under++;
                f_under_cyc = scyc;
            end
            if (in_latch != 0) begin
                if (m_done) begin
                    check("latch_len", latch_n, LATCH);
                    check("latch_high", latch_hi, 0);
                    in_latch = 0;
                end else begin
                    latch_n++;
                    if (m_out) latch_hi++;
                end
            end
            if (m_done) begin
                done_seen++;
                exp_idx = 0;
                check("done_busy", m_busy, 0);
            end
            if (active != 0) begin
                if (cyc == 0) begin
                    cur = exp_q.pop_front();
                    hi = 0; seen_low = 0; bad = 0;
                end
                if (m_out) begin
                    if (seen_low) bad = 1;
                    hi++;
                end else seen_low = 1;
                cyc++; scyc++;
                if (cyc == BITC) begin
                    check("bit_high", bad ? -1 : hi, cur ? 10 : 5);
                    f_bits++;
                    cyc = 0;
                    if (exp_q.size() == 0 && !mon_hs) begin
                        active = 0; in_latch = 1; latch_n = 0; latch_hi = 0; f_send = scyc;
                    end
                end
            end
            if (mon_hs) begin
                check("pixel_index", m_index, exp_idx);
                exp_idx++;
                for (int i = bpp_of(sel) - 1; i >= 0; i--) exp_q.push_back(pixel_data[i]);
                if (active == 0) begin
                    active = 1; cyc = 0; scyc = 0;
                end
            end
        end
    end

    // mode 0: valid whenever pixels remain; mode 2: valid randomly toggled
    task automatic run_frame(input int s, input int npix_drv, input int mode,
                             input int mid_start, input int rst_at);
        int k;
        bit hs, done;
        sel = s; k = 0; done = 0; d0 = done_seen;
        f_bits = 0; f_under = 0; f_under_cyc = -1; f_send = 0;
        pixel_valid = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 30000 && !done; c++) begin
            start = (c == mid_start);
            if (k < npix_drv && (mode != 2 || $urandom_range(0, 1) == 1)) begin
                pixel_valid = 1; pixel_data = pix[k];
            end else begin
                pixel_valid = 0; pixel_data = $urandom;
            end
            @(negedge clk);
            hs = m_ready && pixel_valid;
            @(posedge clk); #1;
            if (hs) k++;
            if (rst_at >= 0 && active != 0 && scyc == rst_at) begin
                check("pre_rst_out", m_out, 1);
                rst_n = 0;
                #1;
                check("rst_out", m_out, 0);
                check("rst_busy", m_busy, 0);
                check("rst_ready", m_ready, 0);
                done = 1;
            end
            if (done_seen != d0) done = 1;
        end
        start = 0;
        pixel_valid = 0;
        if (!done) check("frame_timeout", 0, 1);
        #1;
        check("done_pulse_width", m_done, 0);
    endtask

    task automatic expect_frame(input int bits, input int send, input int under, input int ucyc);
        check("bits_sent", f_bits, bits);
        check("send_cycles", f_send, send);
        check("underrun_cnt", f_under, under);
        if (under > 0) check("underrun_cycle", f_under_cyc, ucyc);
        check("done_cnt", done_seen - d0, 1);
    endtask

    initial begin
        rst_n = 0; start = 0; pixel_valid = 0; pixel_data = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ws_out", m_out, 0);
            check("rst_busy", m_busy, 0);
            check("rst_ready", m_ready, 0);
            check("rst_done", m_done, 0);
            check("rst_underrun", m_under, 0);
            check("rst_index", m_index, 0);
        end
        sel = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // Two-pixel frame, valid held high
        pix[0] = 32'h0080_0000; pix[1] = 32'h0000_0001;
        run_frame(0, 2, 0, -1, -1);
        expect_frame(48, 720, 0, 0);

        // 32-bit all-ones pixel
        pix[0] = 32'hFFFF_FFFF;
        run_frame(2, 1, 0, -1, -1);
        expect_frame(32, 480, 0, 0);

        // Data withheld after pixel 0
        pix[0] = 32'h00A5_3C0F;
        run_frame(1, 1, 0, -1, -1);
        expect_frame(24, 360, 1, 359);

        // Start pulsed while busy
        pix[0] = 32'h0012_3456; pix[1] = 32'h00FE_DCBA; pix[2] = 32'h0055_AA55;
        run_frame(1, 3, 0, 200, -1);
        expect_frame(72, 1080, 0, 0);
        repeat (50) @(posedge clk);
        #1;
        check("no_restart_busy", m_busy, 0);
        check("single_done", done_seen - d0, 1);

        // Reset in SEND cycle 7, then a fresh full frame
        pix[0] = 32'h0080_0000; pix[1] = 32'h0012_3456;
        run_frame(0, 2, 0, -1, 7);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_rst", m_busy, 0);
        pix[0] = 32'h00C3_0F81; pix[1] = 32'h0001_8000;
        run_frame(0, 2, 0, -1, -1);
        expect_frame(48, 720, 0, 0);

        // Random valid toggling
        for (int i = 0; i < 3; i++) pix[i] = $urandom;
        run_frame(1, 3, 2, -1, -1);
        expect_frame(72, 1080, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
